// File: rtl/mem_arbiter_if.sv
// Request/response bundle between core fetch/LSU, the memory arbiter and memory.
// slave = arbiter view, master = core + memory view.
interface mem_arbiter_if;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_done, d_rdata,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_done, d_rdata,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single memory port shared by fetch and load/store: one transaction at a time,
// data has priority except when fetch has been starved STARVE_MAX grants in a row.
module mem_arbiter #(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          ce_i,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

    localparam logic [2:0] LAT  = 3'(MEM_LAT);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_e      state_q;
    logic [3:0]  starve_q;
    logic [2:0]  lat_q;
    logic        src_d_q;
    logic        mem_en_q, mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [31:0] f_rdata_q, d_rdata_q;
    logic        f_rvalid_q, d_done_q, busy_q;
    logic        can_gnt, pick_f, f_gnt, d_gnt;

    // Grants are combinational from the requests but only ever issued from IDLE.
    always_comb begin
        can_gnt = (state_q == ST_IDLE) && ce_i && !reset_i;
        pick_f  = bus.f_req && (!bus.d_req || (starve_q == SMAX));
        f_gnt   = can_gnt && pick_f;
        d_gnt   = can_gnt && bus.d_req && !pick_f;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            lat_q       <= '0;
            src_d_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            f_rvalid_q  <= 1'b0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else if (ce_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (f_gnt) begin
                        mem_addr_q <= bus.f_addr;
                        mem_we_q   <= 1'b0;
                        mem_be_q   <= 4'b1111;
                        src_d_q    <= 1'b0;
                        starve_q   <= '0;
                        mem_en_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end else if (d_gnt) begin
                        mem_addr_q  <= bus.d_addr;
                        mem_we_q    <= bus.d_we;
                        mem_be_q    <= bus.d_we ? bus.d_be : 4'b1111;
                        mem_wdata_q <= bus.d_wdata;
                        src_d_q     <= 1'b1;
                        if (bus.f_req && (starve_q != SMAX))
                            starve_q <= starve_q + 4'd1;
                        mem_en_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_en_q <= 1'b0;
                    if (mem_we_q) begin
                        d_done_q <= 1'b1;
                        state_q  <= ST_RESP;
                    end else begin
                        lat_q   <= LAT;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_q <= 3'd1) begin
                        if (src_d_q) begin
                            d_rdata_q <= bus.mem_rdata;
                            d_done_q  <= 1'b1;
                        end else begin
                            f_rdata_q  <= bus.mem_rdata;
                            f_rvalid_q <= 1'b1;
                        end
                        state_q <= ST_RESP;
                    end else begin
                        lat_q <= lat_q - 3'd1;
                    end
                end
                ST_RESP: begin
                    f_rvalid_q <= 1'b0;
                    d_done_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // mem_en is gated by ce so a frozen ISSUE cycle never strobes memory twice.
    assign bus.f_gnt     = f_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.f_rvalid  = f_rvalid_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q && ce_i;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=2.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce1 = 1'b1;
    logic ce2 = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   ndg;
    bit   fseen;
    logic [31:0] s2;

    mem_arbiter_if ifa ();
    mem_arbiter_if ifb ();

    mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk_i(clk), .reset_i(reset), .ce_i(ce1), .bus(ifa));
    mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) u_dut2 (
        .clk_i(clk), .reset_i(reset), .ce_i(ce2), .bus(ifb));

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Memory models: latency 1 and latency 2, both advancing only on ce.
    always @(posedge clk) if (ifa.mem_en) ifa.mem_rdata <= memfn(ifa.mem_addr);
    always @(posedge clk) begin
        if (ce2) begin
            if (ifb.mem_en) s2 <= memfn(ifb.mem_addr);
            ifb.mem_rdata <= s2;
        end
    end

    task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifa.f_req = 0; ifa.f_addr = 0; ifa.d_req = 0; ifa.d_we = 0;
        ifa.d_be = 0; ifa.d_addr = 0; ifa.d_wdata = 0;
        ifb.f_req = 0; ifb.f_addr = 0; ifb.d_req = 0; ifb.d_we = 0;
        ifb.d_be = 0; ifb.d_addr = 0; ifb.d_wdata = 0;

        // Reset state, requests pending but nothing granted
        ifa.f_req = 1; ifa.d_req = 1;
        #12;
        chk("rst_f_gnt", ifa.f_gnt, 0);
        chk("rst_d_gnt", ifa.d_gnt, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_mem_en", ifa.mem_en, 0);
        chk("rst_mem_be", ifa.mem_be, 0);
        chk("rst_f_rdata", ifa.f_rdata, 0);
        chk("rst_d_rdata", ifa.d_rdata, 0);
        ifa.f_req = 0; ifa.d_req = 0;
        @(negedge clk) reset = 0;
        tick;

        // 1: fetch, latency 1
        ifa.f_req = 1; ifa.f_addr = 32'h100;
        #1 chk("t1_f_gnt", ifa.f_gnt, 1);
        chk("t1_d_gnt", ifa.d_gnt, 0);
        tick; ifa.f_req = 0;
        chk("t1_mem_en", ifa.mem_en, 1);
        chk("t1_mem_addr", ifa.mem_addr, 32'h100);
        chk("t1_mem_we", ifa.mem_we, 0);
        chk("t1_mem_be", ifa.mem_be, 4'hF);
        tick;
        chk("t1_mem_en_off", ifa.mem_en, 0);
        chk("t1_rvalid_early", ifa.f_rvalid, 0);
        tick;
        chk("t1_rvalid", ifa.f_rvalid, 1);
        chk("t1_f_rdata", ifa.f_rdata, 32'hDEADBEEF);
        tick;
        chk("t1_rvalid_off", ifa.f_rvalid, 0);
        chk("t1_busy_off", ifa.busy, 0);

        // 2: simultaneous fetch and load, data wins
        ifa.f_req = 1; ifa.f_addr = 32'h104;
        ifa.d_req = 1; ifa.d_we = 0; ifa.d_addr = 32'h2000;
        #1 chk("t2_d_gnt", ifa.d_gnt, 1);
        chk("t2_f_gnt", ifa.f_gnt, 0);
        tick; ifa.d_req = 0;
        chk("t2_mem_addr", ifa.mem_addr, 32'h2000);
        tick;
        tick;
        chk("t2_d_done", ifa.d_done, 1);
        chk("t2_d_rdata", ifa.d_rdata, memfn(32'h2000));
        chk("t2_f_gnt_busy", ifa.f_gnt, 0);
        tick;
        chk("t2_f_gnt", ifa.f_gnt, 1);
        tick; ifa.f_req = 0;
        tick;
        tick;
        chk("t2_f_rvalid", ifa.f_rvalid, 1);
        chk("t2_f_rdata", ifa.f_rdata, memfn(32'h104));
        tick;

        // 3: starvation limit
        ifa.d_req = 1; ifa.d_we = 0; ifa.d_addr = 32'h2008;
        ifa.f_req = 1; ifa.f_addr = 32'h108;
        ndg = 0; fseen = 0;
        for (int i = 0; i < 60 && !fseen; i++) begin
            #1;
            if (ifa.d_gnt) ndg++;
            if (ifa.f_gnt) fseen = 1;
            if (ifa.f_gnt && ifa.d_gnt) chk("t3_both_gnt", 1, 0);
            tick;
        end
        ifa.f_req = 0; ifa.d_req = 0;
        chk("t3_f_seen", fseen, 1);
        chk("t3_d_gnts", ndg, 4);
        chk("t3_starve_clr", u_dut.starve_q, 0);
        for (int i = 0; i < 20 && ifa.busy; i++) tick;
        chk("t3_idle", ifa.busy, 0);
        chk("t3_f_rdata", ifa.f_rdata, memfn(32'h108));

        // 4: store
        ifa.d_req = 1; ifa.d_we = 1; ifa.d_be = 4'b0011;
        ifa.d_addr = 32'h2004; ifa.d_wdata = 32'h12345678;
        #1 chk("t4_d_gnt", ifa.d_gnt, 1);
        tick; ifa.d_req = 0; ifa.d_we = 0;
        chk("t4_mem_en", ifa.mem_en, 1);
        chk("t4_mem_we", ifa.mem_we, 1);
        chk("t4_mem_be", ifa.mem_be, 4'b0011);
        chk("t4_mem_addr", ifa.mem_addr, 32'h2004);
        chk("t4_mem_wdata", ifa.mem_wdata, 32'h12345678);
        tick;
        chk("t4_d_done", ifa.d_done, 1);
        chk("t4_d_rdata_hold", ifa.d_rdata, memfn(32'h2008));
        tick;
        chk("t4_d_done_off", ifa.d_done, 0);
        chk("t4_addr_hold", ifa.mem_addr, 32'h2004);

        // ce low in IDLE blocks the grant
        ce1 = 0; ifa.f_req = 1; ifa.f_addr = 32'h400;
        #1 chk("ce_f_gnt", ifa.f_gnt, 0);
        tick;
        chk("ce_busy", ifa.busy, 0);
        ce1 = 1;
        #1 chk("ce_f_gnt_on", ifa.f_gnt, 1);
        tick; ifa.f_req = 0;
        tick;
        tick;
        chk("ce_f_rvalid", ifa.f_rvalid, 1);
        chk("ce_f_rdata", ifa.f_rdata, memfn(32'h400));
        tick;

        // 5: reset during WAIT
        ifa.d_req = 1; ifa.d_we = 0; ifa.d_addr = 32'h200C;
        #1 chk("t5_d_gnt", ifa.d_gnt, 1);
        tick; ifa.d_req = 0;
        tick;
        #2 reset = 1;
        #1 chk("t5_busy", ifa.busy, 0);
        chk("t5_mem_en", ifa.mem_en, 0);
        chk("t5_d_done", ifa.d_done, 0);
        chk("t5_d_rdata", ifa.d_rdata, 0);
        chk("t5_mem_addr", ifa.mem_addr, 0);
        ifa.d_req = 1; ifa.d_addr = 32'h2010;
        tick;
        chk("t5_d_done_rst", ifa.d_done, 0);
        chk("t5_d_gnt_rst", ifa.d_gnt, 0);
        reset = 0;
        #1 chk("t5_d_gnt_rel", ifa.d_gnt, 1);
        tick; ifa.d_req = 0;
        tick;
        tick;
        chk("t5_d_done_new", ifa.d_done, 1);
        chk("t5_d_rdata_new", ifa.d_rdata, memfn(32'h2010));
        tick;

        // 6: latency 2 fetch with ce low three cycles inside WAIT
        ifb.f_req = 1; ifb.f_addr = 32'h300;
        #1 chk("t6_f_gnt", ifb.f_gnt, 1);
        tick; ifb.f_req = 0;
        chk("t6_mem_en", ifb.mem_en, 1);
        chk("t6_mem_addr", ifb.mem_addr, 32'h300);
        tick;
        tick;
        ce2 = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t6_rvalid_stall", ifb.f_rvalid, 0);
        end
        ce2 = 1;
        tick;
        chk("t6_f_rvalid", ifb.f_rvalid, 1);
        chk("t6_f_rdata", ifb.f_rdata, memfn(32'h300));
        tick;
        chk("t6_rvalid_off", ifb.f_rvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
